serial_frame_rx: RTL and testbench

Serial frame receiver that consumes the one-bit-per-clock stream leaving the shift-register stage (its serial output `E`) and rebuilds parallel words. Each frame is a start bit, DATA_W data bits LSB-first, an optional even-parity bit and a stop bit. Completed words are presented with a one-cycle valid strobe; malformed frames are flagged and discarded. The block sits directly downstream of the shift register on the same clock, one bit per cycle, with no oversampling.

---
 rtl/serial_frame_rx_if.sv | 23 ++
 rtl/serial_frame_rx.sv | 112 +++++++++++
 tb/tb_serial_frame_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Bus between the shift-register serial output and the frame receiver.
// data_valid is a one-cycle strobe with no ready: the consumer must take data_out on that cycle.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
) ();
    logic              ser_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              parity_err;
    logic              busy;
    logic [1:0]        dbg_state;

    modport master (
        output ser_in,
        input  data_out, data_valid, frame_err, parity_err, busy, dbg_state
    );

    modport slave (
        input  ser_in,
        output data_out, data_valid, frame_err, parity_err, busy, dbg_state
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit (0).
// Define PARITY_CHECK_EN to include the parity bit and the parity_err flag.
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    serial_frame_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] asm_next;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              ferr_q;

    // LSB-first: each new bit enters at the top, so the first bit ends up in bit 0.
    always_comb begin
        asm_next             = asm_reg >> 1;
        asm_next[DATA_W-1]   = bus.ser_in;
    end

`ifdef PARITY_CHECK_EN
    logic par_bad;
    logic perr_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (state == IDLE && bus.ser_in)
                par_bad <= 1'b0;
            else if (state == PARITY)
                par_bad <= (^asm_reg) ^ bus.ser_in;
            else if (state == STOP)
                perr_q <= par_bad;
        end
    end

    assign bus.parity_err = perr_q;
`else
    logic par_bad;
    assign par_bad        = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            asm_reg <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ser_in) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    asm_reg <= asm_next;
                    if (cnt == CW'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: state <= STOP;
`endif
                STOP: begin
                    // A high stop bit is an error only; it never doubles as a start bit.
                    state <= IDLE;
                    if (bus.ser_in)
                        ferr_q <= 1'b1;
                    if (!bus.ser_in && !par_bad) begin
                        dout_q  <= asm_reg;
                        valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != IDLE);
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: vector table, back-to-back and mid-frame reset sequences.
module tb_serial_frame_rx;
    localparam int DATA_W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = DATA_W + 3;
`else
    localparam int FRAME = DATA_W + 2;
`endif

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic [DATA_W-1:0] exp_q[$];
    int   valid_cyc[$];
    vec_t vecs[8];

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded budget", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard: every data_valid pulse must match the head of exp_q
    always @(negedge clk) begin
        if (clr === 1'b0 && bus.data_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("sb_data_out", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        bus.ser_in = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < DATA_W; i++) begin
            bus.ser_in = d[i];
            @(posedge clk); #1;
            check("busy_in_data", 32'(bus.busy), 32'd1);
        end
`ifdef PARITY_CHECK_EN
        bus.ser_in = pb;
        @(posedge clk); #1;
        check("busy_in_parity", 32'(bus.busy), 32'd1);
`else
        if (pb === 1'bx) $display("parity bit unused");
`endif
        bus.ser_in = sb;
        @(posedge clk); #1;
        check("busy_after_stop", 32'(bus.busy), 32'd0);
    endtask

    task automatic idle(input int n);
        bus.ser_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
`ifdef PARITY_CHECK_EN
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F};
`else
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F};
`endif

        clr = 1'b1;
        bus.ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        clr = 1'b0;
        idle(2);
        check("idle_stays_idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_dout);
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit);
            check($sformatf("v%0d_data_valid", i), 32'(bus.data_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_frame_err", i), 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_parity_err", i), 32'(bus.parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_dout));
            idle(1);
            check($sformatf("v%0d_valid_clear", i), 32'(bus.data_valid), 32'd0);
            check($sformatf("v%0d_ferr_clear", i), 32'(bus.frame_err), 32'd0);
            check($sformatf("v%0d_perr_clear", i), 32'(bus.parity_err), 32'd0);
            check($sformatf("v%0d_idle_state", i), 32'(bus.dbg_state), 32'd0);
            check($sformatf("v%0d_dout_hold", i), 32'(bus.data_out), 32'(vecs[i].exp_dout));
        end

        // back-to-back frames with no idle cycle between them
        n0 = valid_cyc.size();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("b2b_first_valid", 32'(bus.data_valid), 32'd1);
        check("b2b_first_data", 32'(bus.data_out), 32'h3C);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("b2b_second_valid", 32'(bus.data_valid), 32'd1);
        check("b2b_second_data", 32'(bus.data_out), 32'hC3);
        idle(1);
        check("b2b_pulse_count", 32'(valid_cyc.size() - n0), 32'd2);
        if (valid_cyc.size() - n0 == 2)
            check("b2b_spacing", 32'(valid_cyc[n0+1] - valid_cyc[n0]), 32'(FRAME));

        // asynchronous clear after four data bits
        bus.ser_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_before_clr", 32'(bus.busy), 32'd1);
        #2;
        clr = 1'b1;
        bus.ser_in = 1'b0;
        #1;
        check("clr_async_data_out", 32'(bus.data_out), 32'd0);
        check("clr_async_valid", 32'(bus.data_valid), 32'd0);
        check("clr_async_ferr", 32'(bus.frame_err), 32'd0);
        check("clr_async_perr", 32'(bus.parity_err), 32'd0);
        check("clr_async_busy", 32'(bus.busy), 32'd0);
        check("clr_async_state", 32'(bus.dbg_state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        idle(1);
        check("after_clr_no_flags", 32'({bus.data_valid, bus.frame_err, bus.parity_err}), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("post_clr_valid", 32'(bus.data_valid), 32'd1);
        check("post_clr_data", 32'(bus.data_out), 32'h5A);
        idle(1);
        check("post_clr_valid_clear", 32'(bus.data_valid), 32'd0);

        idle(2);
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
